// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns memory-stage control fields into
// byte-enabled req/ack bus transactions and formats load data for writeback.
module dmem_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        dmem_sel,
    input  logic [1:0]  w_sel,
    input  logic [2:0]  r_sel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [2:0]    ld_type;
    logic [1:0]    ld_off;
    logic          ld_en;

    logic          is_store, is_load, is_half, is_word, mis, go;
    logic [3:0]    be_n;
    logic [31:0]   wd_n;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   fmt;

    always_comb begin
        is_store = valid & dmem_sel & (w_sel != 2'b11);
        is_load  = valid & ~dmem_sel & ((r_sel == 3'b000) | (r_sel == 3'b010) |
                   (r_sel == 3'b011) | (r_sel == 3'b100) | (r_sel == 3'b101));
        is_half  = is_store ? (w_sel == 2'b01) : ((r_sel == 3'b010) | (r_sel == 3'b101));
        is_word  = is_store ? (w_sel == 2'b10) : (r_sel == 3'b011);
        mis      = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
        go       = (is_store | is_load) & ~mis;
    end

    always_comb begin
        be_n = 4'b1111;
        wd_n = wdata;
        if (is_store & is_half) begin
            be_n = addr[1] ? 4'b1100 : 4'b0011;
            wd_n = {2{wdata[15:0]}};
        end else if (is_store & ~is_word) begin
            be_n = 4'b0001 << addr[1:0];
            wd_n = {4{wdata[7:0]}};
        end
    end

    // Lane selection uses the offset captured at issue, not the live address.
    always_comb begin
        lane_b = bus_rdata[8*ld_off +: 8];
        lane_h = ld_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (ld_type)
            3'b000:  fmt = {{24{lane_b[7]}}, lane_b};
            3'b010:  fmt = {{16{lane_h[15]}}, lane_h};
            3'b100:  fmt = {24'd0, lane_b};
            3'b101:  fmt = {16'd0, lane_h};
            default: fmt = bus_rdata;
        endcase
    end

    always_comb begin
        state_n = state;
        stall   = 1'b0;
        bus_req = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    state_n = REQ;
                    stall   = 1'b1;
                end
            end
            REQ: begin
                bus_req = 1'b1;
                stall   = 1'b1;
                if (bus_ack || cnt == LAST)
                    state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
        stall   = stall & ~rst;
        bus_req = bus_req & ~rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ld_type   <= 3'b111;
            ld_off    <= 2'b00;
            ld_en     <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= 4'b0000;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            rdata     <= 32'd0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state    <= state_n;
            misalign <= (state == IDLE) & (is_store | is_load) & mis;
            bus_err  <= 1'b0;
            if (state == IDLE && go) begin
                bus_addr  <= {addr[31:2], 2'b00};
                bus_we    <= is_store;
                bus_be    <= be_n;
                bus_wdata <= wd_n;
                ld_type   <= r_sel;
                ld_off    <= addr[1:0];
                ld_en     <= is_load;
                cnt       <= '0;
            end
            if (state == REQ) begin
                cnt <= cnt + 1'b1;
                if (bus_ack) begin
                    if (ld_en)
                        rdata <= fmt;
                end else if (cnt == LAST) begin
                    bus_err <= 1'b1;
                    if (ld_en)
                        rdata <= 32'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus random
// accesses checked against a byte-level reference model.
module tb_dmem_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        dmem_sel = 1'b0;
    logic [1:0]  w_sel = 2'b11;
    logic [2:0]  r_sel = 3'b111;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        stall;
    logic [31:0] rdata;
    logic        misalign;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    int checks = 0;
    int errors = 0;
    logic [31:0] mrd = 32'd0;

    dmem_ctrl #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .valid(valid), .dmem_sel(dmem_sel),
        .w_sel(w_sel), .r_sel(r_sel), .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .misalign(misalign), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic st, input logic [1:0] ws, input logic [2:0] rs);
        if (st) return (ws == 2'b00) ? 1 : (ws == 2'b01) ? 2 : 4;
        return (rs == 3'b000 || rs == 3'b100) ? 1 :
               (rs == 3'b010 || rs == 3'b101) ? 2 : 4;
    endfunction

    function automatic logic is_acc(input logic v, input logic st,
                                    input logic [1:0] ws, input logic [2:0] rs);
        if (!v) return 1'b0;
        if (st) return ws != 2'b11;
        return rs == 3'b000 || rs == 3'b010 || rs == 3'b011 ||
               rs == 3'b100 || rs == 3'b101;
    endfunction

    function automatic logic [3:0] exp_be(input logic st, input int n, input logic [31:0] a);
        logic [3:0] be;
        int off;
        off = int'(a % 4);
        be = 4'b0000;
        for (int k = 0; k < 4; k++)
            be[k] = !st || (k >= off && k < off + n);
        return be;
    endfunction

    function automatic logic [31:0] exp_wd(input int n, input logic [31:0] d);
        logic [31:0] r;
        r = 32'd0;
        for (int k = 0; k < 4; k++)
            r[8*k +: 8] = d[8*(k % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_ld(input logic [2:0] rs, input logic [31:0] a,
                                           input logic [31:0] word);
        int n;
        logic [31:0] v, mask;
        n = nbytes(1'b0, 2'b00, rs);
        v = word >> (8 * (a % 4));
        if (n < 4) begin
            mask = (32'd1 << (8 * n)) - 32'd1;
            v = v & mask;
            if ((rs == 3'b000 || rs == 3'b010) && v[8*n-1])
                v = v | ~mask;
        end
        return v;
    endfunction

    task automatic run_op(input string tag, input logic v, input logic st,
                          input logic [1:0] ws, input logic [2:0] rs,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] word, input int ack_at);
        int n, nstall, nreq, ereq;
        logic acc, al, done;
        n   = nbytes(st, ws, rs);
        acc = is_acc(v, st, ws, rs);
        al  = (a % n) == 0;
        @(negedge clk);
        valid = v; dmem_sel = st; w_sel = ws; r_sel = rs;
        addr = a; wdata = d; bus_ack = 1'b0; bus_rdata = word;
        nstall = 0; nreq = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (c > 0) begin
                @(negedge clk);
                bus_ack = (c == ack_at);
            end
            #1;
            if (bus_req) begin
                nreq++;
                chk({tag, ".addr"}, bus_addr, {a[31:2], 2'b00});
                chk({tag, ".be"}, {28'd0, bus_be}, {28'd0, exp_be(st, n, a)});
                chk({tag, ".we"}, {31'd0, bus_we}, {31'd0, st});
                if (st) chk({tag, ".wdata"}, bus_wdata, exp_wd(n, d));
            end
            if (stall) nstall++;
            else done = 1'b1;
        end
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        bus_ack = 1'b0;
        if (acc && al) begin
            ereq = (ack_at >= 1 && ack_at <= T) ? ack_at : T;
            chk({tag, ".nreq"}, nreq, ereq);
            chk({tag, ".nstall"}, nstall, ereq + 1);
            chk({tag, ".err"}, {31'd0, bus_err}, {31'd0, ack_at < 1 || ack_at > T});
            if (!st) mrd = (ack_at >= 1 && ack_at <= T) ? exp_ld(rs, a, word) : 32'd0;
            chk({tag, ".rdata"}, rdata, mrd);
            @(negedge clk);
            valid = 1'b0;
            #1;
            chk({tag, ".err_off"}, {31'd0, bus_err}, 32'd0);
        end else begin
            chk({tag, ".nstall"}, nstall, 0);
            chk({tag, ".nreq"}, nreq, 0);
            @(negedge clk);
            valid = 1'b0;
            #1;
            chk({tag, ".mis"}, {31'd0, misalign}, {31'd0, acc});
            chk({tag, ".rdata"}, rdata, mrd);
            @(negedge clk);
            #1;
            chk({tag, ".mis_off"}, {31'd0, misalign}, 32'd0);
        end
    endtask

    initial begin
        logic [2:0] rcodes [8];
        rcodes = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b111, 3'b001, 3'b110};

        valid = 1'b1; r_sel = 3'b011;
        #2;
        chk("rst.stall", {31'd0, stall}, 32'd0);
        chk("rst.req", {31'd0, bus_req}, 32'd0);
        chk("rst.rdata", rdata, 32'd0);
        chk("rst.be", {28'd0, bus_be}, 32'd0);
        chk("rst.flags", {30'd0, misalign, bus_err}, 32'd0);
        @(negedge clk);
        valid = 1'b0;
        rst = 1'b0;

        run_op("sw", 1, 1, 2'b10, 3'b111, 32'h100, 32'hDEADBEEF, 32'd0, 2);
        run_op("sb", 1, 1, 2'b00, 3'b111, 32'h103, 32'h000000A5, 32'd0, 1);
        run_op("lb", 1, 0, 2'b11, 3'b000, 32'h102, 32'd0, 32'h1280FF34, 1);
        run_op("lhu", 1, 0, 2'b11, 3'b101, 32'h102, 32'd0, 32'h1280FF34, 3);
        run_op("lw_mis", 1, 0, 2'b11, 3'b011, 32'h101, 32'd0, 32'hCAFEF00D, 1);
        run_op("sh_mis", 1, 1, 2'b01, 3'b111, 32'h203, 32'h1234, 32'd0, 1);
        run_op("lw_to", 1, 0, 2'b11, 3'b011, 32'h40, 32'd0, 32'h55555555, 0);

        bus_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("late.req", {31'd0, bus_req}, 32'd0);
            chk("late.rdata", rdata, 32'd0);
        end
        bus_ack = 1'b0;

        run_op("lh_sx", 1, 0, 2'b11, 3'b010, 32'h80, 32'd0, 32'h0000F00F, 4);

        for (int i = 0; i < 40; i++) begin
            logic st;
            logic [1:0] ws;
            logic [2:0] rs;
            logic [31:0] a;
            st = 1'($urandom);
            ws = 2'($urandom);
            rs = rcodes[$urandom_range(0, 7)];
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b10;
            run_op($sformatf("rnd%0d", i), ($urandom_range(0, 7) != 0), st, ws, rs,
                   a, $urandom, $urandom, $urandom_range(1, T + 2));
        end

        @(negedge clk);
        valid = 1'b1; dmem_sel = 1'b0; r_sel = 3'b011; addr = 32'h200;
        @(negedge clk);
        #1;
        chk("rstm.req_pre", {31'd0, bus_req}, 32'd1);
        #1;
        rst = 1'b1;
        mrd = 32'd0;
        #1;
        chk("rstm.req", {31'd0, bus_req}, 32'd0);
        chk("rstm.stall", {31'd0, stall}, 32'd0);
        chk("rstm.outs", {bus_addr[31:4], bus_be}, 32'd0);
        chk("rstm.rdata", rdata, 32'd0);
        valid = 1'b0;
        bus_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rstm.ack_ign", {31'd0, bus_req}, 32'd0);
        bus_ack = 1'b0;
        run_op("pass", 1, 1, 2'b11, 3'b111, 32'h300, 32'h1, 32'd0, 1);
        run_op("pass_ld", 1, 0, 2'b11, 3'b111, 32'h301, 32'h1, 32'd0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller for the pipelined RISC-V core. It consumes the memory-stage control fields produced by the pipeline control decoders (`dmem_sel`, `w_sel`, `r_sel`) together with the effective address and store data. It turns them into byte-enabled, word-aligned transactions on a req/ack memory bus, stalls the pipeline until the bus acknowledges, and returns sign- or zero-extended load data for writeback. It sits between the execute/memory pipeline register and the data memory or bus fabric.

## Interface
- `TIMEOUT`, default 16: max cycles `bus_req` stays high without `bus_ack` before the access is aborted (≥1).
- `clk` in 1: clock, rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `valid` in 1: stage holds a real instruction.
- `dmem_sel` in 1: 1 = store, 0 = not a store.
- `w_sel` in 2: store width; 00 byte, 01 half, 10 word, 11 no write.
- `r_sel` in 3: load type; 000 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 111 no load; other codes are treated as no load.
- `addr` in 32: effective byte address.
- `wdata` in 32: store data, rs2 value.
- `stall` out 1: hold the pipeline.
- `rdata` out 32: formatted load data.
- `misalign` out 1: one-cycle misaligned-access pulse.
- `bus_err` out 1: one-cycle timeout pulse.
- `bus_req`, `bus_we` out 1: request and write strobe.
- `bus_addr` out 32: word address, bits [1:0] = 00.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_ack` in 1: transaction complete.
- `bus_rdata` in 32: read word, valid with `bus_ack`.

## Operation
- Access classes:
  - store: `valid & dmem_sel & w_sel!=11`
  - load: `valid & !dmem_sel & r_sel` is one of the five load codes
  - anything else is a pass-through; no bus activity, `stall`=0.
- Alignment rules:
  - half (SH/LH/LHU) requires `addr[0]=0`.
  - word (SW/LW) requires `addr[1:0]=00`.
  - A misaligned access raises `misalign` for one cycle in IDLE, issues no bus request, does not stall, and leaves `rdata` unchanged.
- FSM states: IDLE, REQ, DONE.
  - IDLE → REQ on an aligned access. `bus_addr`, `bus_we`, `bus_be` and `bus_wdata` are registered. `stall`=1 in this cycle.
  - REQ: `bus_req`=1 and `stall`=1; all bus outputs are held stable. On `bus_ack` → DONE; for a load, the formatted `bus_rdata` is captured into `rdata`. A wait counter increments each REQ cycle. If it reaches `TIMEOUT` with no ack → DONE, `bus_err` pulses, and `rdata` is set to 0 for loads.
  - DONE: `stall`=0 and `bus_req`=0, so the pipeline advances. Next state is always IDLE; a new access is not accepted in DONE.
- Byte enables and store data:
  - SB: `bus_be`=0001<<`addr[1:0]`; `bus_wdata`={4{wdata[7:0]}}.
  - SH: `bus_be`=`addr[1]`?1100:0011; `bus_wdata`={2{wdata[15:0]}}.
  - SW: `bus_be`=1111; `bus_wdata`=`wdata`.
  - Loads: `bus_be`=1111 and `bus_we`=0.
- Load formatting:
  - The byte lane is selected by `addr[1:0]`; the half lane by `addr[1]`.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- `rdata` is registered and holds its value until the next load completes.
- `bus_ack` outside REQ is ignored.

## Timing
- Reset values: state IDLE, counter 0. `bus_req`, `bus_we`, `bus_be`, `bus_addr`, `bus_wdata`, `rdata`, `misalign` and `bus_err` are all 0. `stall` is forced to 0 while `rst` is high.
- Minimum access is 3 cycles: present (IDLE), REQ with same-cycle ack, then DONE.
- Generally, an access takes 2 + N cycles, where N is the number of REQ cycles up to and including the ack. `stall` is high for the first N+1 of those cycles.
- The pipeline must hold `valid`, `addr`, `wdata` and the control fields stable while `stall`=1. The block samples them only in IDLE.
- `misalign` and `bus_err` are registered pulses. They assert the cycle after the causing condition and last exactly one cycle.
- `rst` mid-transaction:
  - `bus_req` drops asynchronously and the transaction is abandoned.
  - A later `bus_ack` is ignored.
  - After reset releases, the block resumes from IDLE.

## Test plan
- SW, `addr`=0x100, `wdata`=0xDEADBEEF, ack on the 2nd REQ cycle → `bus_addr`=0x100, `bus_be`=1111, `bus_we`=1. `stall` is high for 3 cycles, then DONE.
- SB, `addr`=0x103, `wdata`=0x000000A5 → `bus_be`=1000, `bus_wdata`=0xA5A5A5A5, `bus_addr`=0x100.
- LB at 0x102 with `bus_rdata`=0x1280FF34 → `rdata`=0xFFFFFF80. LHU at 0x102 with the same word → `rdata`=0x00001280.
- LW at 0x101 → `misalign` pulses, `bus_req` never asserts, `stall`=0, and `rdata` keeps its prior value.
- LW with `TIMEOUT`=4 and no ack → `bus_req` is high for 4 cycles, then `bus_err` pulses and `rdata`=0. A late `bus_ack` is ignored.
- `rst` asserted during REQ → `bus_req` goes to 0 immediately and all outputs take their reset values. After release, a pass-through op (`w_sel`=11, `r_sel`=111) produces no `stall`.
